dff_serial_tx: RTL and testbench

//   Parallel-in/serial-out frame transmitter: the sending end of the serial link whose

---
 rtl/dff_serial_tx_if.sv | 31 +++
 rtl/dff_serial_tx.sv | 146 ++++++++++++++
 tb/tb_dff_serial_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_serial_tx_if.sv
// Load handshake and serial line of the dff_serial_tx frame transmitter.
interface dff_serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              tx_sd;
    logic              tx_bit_start;
    logic              busy;

    // Word source side
    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  tx_sd,
        input  tx_bit_start,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output tx_sd,
        output tx_bit_start,
        output busy
    );
endinterface

// File: rtl/dff_serial_tx.sv
// Parallel-in/serial-out frame transmitter: start(0), data LSB-first,
// optional even parity, stop(1); each bit held DIV clocks, line idles high.
// Define DFF_SERIAL_TX_PARITY_EN to insert the even-parity bit after the data.
module dff_serial_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = 4
) (
    input  logic             clk,
    input  logic             Rd,
    dff_serial_tx_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] sreg;
    logic              tx_sd_q;
    logic              bit_start_q;
    logic              busy_q;
    logic              ready_q;
`ifdef DFF_SERIAL_TX_PARITY_EN
    logic              par_q;
`endif

    logic              bit_end;
    logic [DATA_W-1:0] sreg_shr;

    // Last clock of the current bit period, and the shift register after one shift
    assign bit_end  = (bit_cnt == CNT_LAST);
    assign sreg_shr = sreg >> 1;

    // Frame sequencer with registered line, strobe and handshake outputs
    always_ff @(posedge clk) begin
        if (Rd) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            sreg        <= '0;
            tx_sd_q     <= 1'b1;
            bit_start_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef DFF_SERIAL_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            bit_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load_valid && ready_q) begin
                        state       <= S_START;
                        sreg        <= bus.load_data;
`ifdef DFF_SERIAL_TX_PARITY_EN
                        par_q       <= ^bus.load_data;
`endif
                        bit_cnt     <= '0;
                        tx_sd_q     <= 1'b0;
                        bit_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state       <= S_DATA;
                        bit_cnt     <= '0;
                        idx         <= '0;
                        tx_sd_q     <= sreg[0];
                        bit_start_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt     <= '0;
                        bit_start_q <= 1'b1;
                        sreg        <= sreg_shr;
                        if (idx == IDX_LAST) begin
`ifdef DFF_SERIAL_TX_PARITY_EN
                            state   <= S_PAR;
                            tx_sd_q <= par_q;
`else
                            state   <= S_STOP;
                            tx_sd_q <= 1'b1;
`endif
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            tx_sd_q <= sreg_shr[0];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`ifdef DFF_SERIAL_TX_PARITY_EN
                S_PAR: begin
                    if (bit_end) begin
                        state       <= S_STOP;
                        bit_cnt     <= '0;
                        tx_sd_q     <= 1'b1;
                        bit_start_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                        tx_sd_q <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    tx_sd_q <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Outputs straight from flops
    assign bus.tx_sd        = tx_sd_q;
    assign bus.tx_bit_start = bit_start_q;
    assign bus.busy         = busy_q;
    assign bus.load_ready   = ready_q;
endmodule

// File: tb/tb_dff_serial_tx.sv
// Scoreboard bench for dff_serial_tx: an 8-bit/DIV=4 instance and a 1-bit/DIV=1 instance.
module tb_dff_serial_tx;
    localparam int unsigned DW_A  = 8;
    localparam int unsigned DIV_A = 4;
    localparam int unsigned DW_B  = 1;
    localparam int unsigned DIV_B = 1;
`ifdef DFF_SERIAL_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned NB_A = DW_A + 2 + PB;
    localparam int unsigned NB_B = DW_B + 2 + PB;
    localparam int unsigned F_A  = NB_A * DIV_A;
    localparam int unsigned F_B  = NB_B * DIV_B;

    typedef struct packed {
        logic sd;
        logic bs;
        logic bz;
    } exp_t;

    logic clk = 1'b0;
    logic rd_a;
    logic rd_b;
    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    dff_serial_tx_if #(.DATA_W(DW_A)) a_if ();
    dff_serial_tx_if #(.DATA_W(DW_B)) b_if ();

    dff_serial_tx #(.DATA_W(DW_A), .DIV(DIV_A)) dut_a (.clk(clk), .Rd(rd_a), .bus(a_if));
    dff_serial_tx #(.DATA_W(DW_B), .DIV(DIV_B)) dut_b (.clk(clk), .Rd(rd_b), .bus(b_if));

    always #5 clk = ~clk;

    // Expected per-clock {tx_sd, tx_bit_start, busy} for one frame of instance A
    task automatic push_a(input logic [DW_A-1:0] d);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW_A); i++) bits.push_back(d[i]);
`ifdef DFF_SERIAL_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < int'(DIV_A); k++) begin
                e.sd = bits[i];
                e.bs = (k == 0);
                e.bz = 1'b1;
                sb_a.push_back(e);
            end
        end
    endtask

    // Same for instance B
    task automatic push_b(input logic [DW_B-1:0] d);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW_B); i++) bits.push_back(d[i]);
`ifdef DFF_SERIAL_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < int'(DIV_B); k++) begin
                e.sd = bits[i];
                e.bs = (k == 0);
                e.bz = 1'b1;
                sb_b.push_back(e);
            end
        end
    endtask

    // Bounded wait (at negedges) for instance A to be ready
    task automatic wait_ready_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_if.load_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_ready_a: load_ready=%b, required 1 within 200 clks", a_if.load_ready);
    endtask

    task automatic test_reset();
        rd_a = 1'b1;
        rd_b = 1'b1;
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'hFF;
        b_if.load_valid = 1'b1;
        b_if.load_data  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start} !== 4'b1100) begin
                n_bad++;
                $display("FAIL reset_a clk %0d: sd/rdy/busy/bs=%b%b%b%b, required 1100", i,
                         a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start);
            end
            n_cmp++;
            if ({b_if.tx_sd, b_if.load_ready, b_if.busy, b_if.tx_bit_start} !== 4'b1100) begin
                n_bad++;
                $display("FAIL reset_b clk %0d: sd/rdy/busy/bs=%b%b%b%b, required 1100", i,
                         b_if.tx_sd, b_if.load_ready, b_if.busy, b_if.tx_bit_start);
            end
        end
        rd_a = 1'b0;
        rd_b = 1'b0;
        a_if.load_valid = 1'b0;
        b_if.load_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_if.tx_sd, a_if.load_ready, a_if.busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_release_a: sd/rdy/busy=%b%b%b, required 110",
                     a_if.tx_sd, a_if.load_ready, a_if.busy);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        exp_t e;
        int   nbs;
        wait_ready_a(ok);
        if (!ok) return;
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'hA5;
        push_a(8'hA5);
        @(posedge clk);
        #1 a_if.load_valid = 1'b0;
        nbs = 0;
        for (int i = 0; i < int'(F_A); i++) begin
            @(negedge clk);
            e = sb_a.pop_front();
            nbs += int'(a_if.tx_bit_start);
            n_cmp++;
            if ({a_if.tx_sd, a_if.tx_bit_start, a_if.busy} !== e) begin
                n_bad++;
                $display("FAIL basic clk %0d: sd/bs/busy=%b%b%b, required %b", i,
                         a_if.tx_sd, a_if.tx_bit_start, a_if.busy, e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({a_if.tx_sd, a_if.load_ready, a_if.busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL basic_end: sd/rdy/busy=%b%b%b, required 110",
                     a_if.tx_sd, a_if.load_ready, a_if.busy);
        end
        n_cmp++;
        if (nbs !== int'(NB_A)) begin
            n_bad++;
            $display("FAIL basic_pulses: got %0d tx_bit_start pulses, required %0d", nbs, NB_A);
        end
    endtask

    task automatic test_parity();
        logic [7:0] dv [2];
        logic       pv [2];
        bit         ok;
        exp_t       e;
        dv[0] = 8'h07; pv[0] = 1'b1;
        dv[1] = 8'hA5; pv[1] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            wait_ready_a(ok);
            if (!ok) return;
            a_if.load_valid = 1'b1;
            a_if.load_data  = dv[f];
            push_a(dv[f]);
            @(posedge clk);
            #1 a_if.load_valid = 1'b0;
            for (int i = 0; i < int'(F_A); i++) begin
                @(negedge clk);
                e = sb_a.pop_front();
                n_cmp++;
                if ({a_if.tx_sd, a_if.tx_bit_start, a_if.busy} !== e) begin
                    n_bad++;
                    $display("FAIL parity_frame %0d clk %0d: sd/bs/busy=%b%b%b, required %b", f, i,
                             a_if.tx_sd, a_if.tx_bit_start, a_if.busy, e);
                end
`ifdef DFF_SERIAL_TX_PARITY_EN
                if (i == int'((DW_A + 1) * DIV_A)) begin
                    n_cmp++;
                    if (a_if.tx_sd !== pv[f]) begin
                        n_bad++;
                        $display("FAIL parity_bit %0d: tx_sd=%b, required %b", f, a_if.tx_sd, pv[f]);
                    end
                end
`endif
            end
            @(negedge clk);
            n_cmp++;
            if (a_if.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL parity_len %0d: busy=%b after %0d clks, required 0", f, a_if.busy, F_A);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        wait_ready_a(ok);
        if (!ok) return;
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'h3C;
        push_a(8'h3C);
        @(posedge clk);
        #1 a_if.load_data = 8'hC3;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < int'(F_A); i++) begin
                @(negedge clk);
                e = sb_a.pop_front();
                n_cmp++;
                if ({a_if.tx_sd, a_if.tx_bit_start, a_if.busy} !== e) begin
                    n_bad++;
                    $display("FAIL b2b frame %0d clk %0d: sd/bs/busy=%b%b%b, required %b", f, i,
                             a_if.tx_sd, a_if.tx_bit_start, a_if.busy, e);
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start} !== 4'b1100) begin
                n_bad++;
                $display("FAIL b2b_gap %0d: sd/rdy/busy/bs=%b%b%b%b, required 1100", f,
                         a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start);
            end
            if (f == 0) begin
                push_a(8'hC3);
                @(posedge clk);
                #1 a_if.load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        bit   ok;
        exp_t e;
        wait_ready_a(ok);
        if (!ok) return;
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'hFF;
        push_a(8'hFF);
        @(posedge clk);
        #1 a_if.load_valid = 1'b0;
        // Clocks 0..20: start bit plus data bits 0..3 plus first clock of data bit 4
        for (int i = 0; i < int'(DIV_A * 5 + 1); i++) begin
            @(negedge clk);
            e = sb_a.pop_front();
            n_cmp++;
            if ({a_if.tx_sd, a_if.tx_bit_start, a_if.busy} !== e) begin
                n_bad++;
                $display("FAIL abort_pre clk %0d: sd/bs/busy=%b%b%b, required %b", i,
                         a_if.tx_sd, a_if.tx_bit_start, a_if.busy, e);
            end
        end
        rd_a = 1'b1;
        @(posedge clk);
        #1 rd_a = 1'b0;
        sb_a.delete();
        @(negedge clk);
        n_cmp++;
        if ({a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start} !== 4'b1100) begin
            n_bad++;
            $display("FAIL abort_after: sd/rdy/busy/bs=%b%b%b%b, required 1100",
                     a_if.tx_sd, a_if.load_ready, a_if.busy, a_if.tx_bit_start);
        end
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'h01;
        push_a(8'h01);
        @(posedge clk);
        #1 a_if.load_valid = 1'b0;
        for (int i = 0; i < int'(F_A); i++) begin
            @(negedge clk);
            e = sb_a.pop_front();
            n_cmp++;
            if ({a_if.tx_sd, a_if.tx_bit_start, a_if.busy} !== e) begin
                n_bad++;
                $display("FAIL abort_next clk %0d: sd/bs/busy=%b%b%b, required %b", i,
                         a_if.tx_sd, a_if.tx_bit_start, a_if.busy, e);
            end
        end
    endtask

    task automatic test_div1();
        exp_t e;
        @(negedge clk);
        n_cmp++;
        if (b_if.load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL div1_ready: load_ready=%b, required 1", b_if.load_ready);
        end
        b_if.load_valid = 1'b1;
        b_if.load_data  = 1'b1;
        push_b(1'b1);
        @(posedge clk);
        // New word offered while busy must not be taken
        #1 b_if.load_data = 1'b0;
        for (int i = 0; i < int'(F_B); i++) begin
            @(negedge clk);
            e = sb_b.pop_front();
            n_cmp++;
            if ({b_if.tx_sd, b_if.tx_bit_start, b_if.busy} !== e) begin
                n_bad++;
                $display("FAIL div1 clk %0d: sd/bs/busy=%b%b%b, required %b", i,
                         b_if.tx_sd, b_if.tx_bit_start, b_if.busy, e);
            end
        end
        @(posedge clk);
        #1 b_if.load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({b_if.tx_sd, b_if.load_ready, b_if.busy, b_if.tx_bit_start} !== 4'b1100) begin
                n_bad++;
                $display("FAIL div1_idle %0d: sd/rdy/busy/bs=%b%b%b%b, required 1100", i,
                         b_if.tx_sd, b_if.load_ready, b_if.busy, b_if.tx_bit_start);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_abort();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
